// File: rtl/pong_ball.sv
// pong_ball: game-logic stage that runs one ball-physics update per video frame.
// It owns serve/play/score sequencing and the two score counters. The ball
// sprite position (top-left pixel) feeds the display stage.
//
// Ports:
//   clk, rst           pixel clock, synchronous active-high reset
//   frame_tick         one-cycle pulse per frame (start of vertical blank)
//   p1_y, p2_y         paddle top edges from the paddle/input logic
//   p1_srv, p2_srv     serve buttons (level)
//   ball_x, ball_y     ball top-left pixel
//   p1_score, p2_score point counters (saturate at 15)
//   state              0=SERVE 1=PLAY 2=SCORED 3=GAMEOVER
//   point              one-cycle pulse when a point is awarded
// All outputs are registered.
module pong_ball #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int BALL_SIZE   = 8,
  parameter int PADDLE_W    = 8,
  parameter int PADDLE_H    = 50,
  parameter int P1_X        = 40,
  parameter int P2_X        = 600,
  parameter int SPEED       = 2,
  parameter int START_X     = 320,
  parameter int START_Y     = 240,
  parameter int HOLD_FRAMES = 60,
  parameter int WIN_SCORE   = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [9:0] p1_y,
  input  logic [9:0] p2_y,
  input  logic       p1_srv,
  input  logic       p2_srv,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] state,
  output logic       point
);

  typedef enum logic [1:0] {S_SERVE = 2'd0, S_PLAY = 2'd1, S_SCORED = 2'd2, S_OVER = 2'd3} state_t;

  localparam int HW = $clog2(HOLD_FRAMES + 1);

  // Geometry in 11 bits so sums like ball_y + BALL_SIZE + SPEED never wrap.
  localparam logic [10:0] L_SW    = 11'(SCREEN_W);
  localparam logic [10:0] L_SH    = 11'(SCREEN_H);
  localparam logic [10:0] L_BALL  = 11'(BALL_SIZE);
  localparam logic [10:0] L_PH    = 11'(PADDLE_H);
  localparam logic [10:0] L_P1R   = 11'(P1_X + PADDLE_W);  // right face of left paddle
  localparam logic [10:0] L_P2X   = 11'(P2_X);
  localparam logic [10:0] L_SPEED = 11'(SPEED);
  localparam logic [9:0]  L_SX    = 10'(START_X);
  localparam logic [9:0]  L_SY    = 10'(START_Y);
  localparam logic [HW-1:0] L_HOLD = HW'(HOLD_FRAMES);
  localparam logic [3:0]  L_WIN   = 4'(WIN_SCORE);

  // dir_x: 1 = right. dir_y: 1 = down. server: 0 = P1, 1 = P2.
  state_t        st_q, st_n;
  logic          dir_x, dir_y, serve_tog, server;
  logic [HW-1:0] hold_cnt;

  logic          dir_x_d, dir_y_d, serve_tog_d, server_d, point_d;
  logic [HW-1:0] hold_cnt_d;
  logic [9:0]    ball_x_d, ball_y_d;
  logic [3:0]    p1_score_d, p2_score_d;

  logic [10:0]   bx, by, p1, p2;
  logic          ov1, ov2;
  logic [9:0]    x_n, y_n;
  logic          dx_n, dy_n, miss_l, miss_r;
  logic          serve_req, hold_done;
  logic [HW-1:0] hold_inc;

  assign bx = {1'b0, ball_x};
  assign by = {1'b0, ball_y};
  assign p1 = {1'b0, p1_y};
  assign p2 = {1'b0, p2_y};

  // Vertical overlap with each paddle, from the pre-update ball_y.
  assign ov1 = (by + L_BALL > p1) && (by < p1 + L_PH);
  assign ov2 = (by + L_BALL > p2) && (by < p2 + L_PH);

  assign serve_req = server ? p2_srv : p1_srv;
  assign hold_inc  = hold_cnt + 1'b1;
  assign hold_done = frame_tick && (hold_inc == L_HOLD);

  // Vertical step candidate.
  always_comb begin
    y_n  = ball_y;
    dy_n = dir_y;
    if (!dir_y) begin
      if (by <= L_SPEED) begin
        y_n  = '0;
        dy_n = 1'b1;
      end else begin
        y_n = 10'(by - L_SPEED);
      end
    end else begin
      if (by + L_BALL + L_SPEED >= L_SH) begin
        y_n  = 10'(L_SH - L_BALL);
        dy_n = 1'b0;
      end else begin
        y_n = 10'(by + L_SPEED);
      end
    end
  end

  // Horizontal step candidate. The bounce test only fires when this step
  // would carry the ball across the paddle face; otherwise it passes through.
  always_comb begin
    x_n    = ball_x;
    dx_n   = dir_x;
    miss_l = 1'b0;
    miss_r = 1'b0;
    if (!dir_x) begin
      if (bx >= L_P1R && (bx - L_SPEED) < L_P1R && ov1) begin
        x_n  = 10'(L_P1R);
        dx_n = 1'b1;
      end else if (bx <= L_SPEED) begin
        miss_l = 1'b1;
      end else begin
        x_n = 10'(bx - L_SPEED);
      end
    end else begin
      if (bx + L_BALL <= L_P2X && bx + L_BALL + L_SPEED > L_P2X && ov2) begin
        x_n  = 10'(L_P2X - L_BALL);
        dx_n = 1'b0;
      end else if (bx + L_BALL + L_SPEED >= L_SW) begin
        miss_r = 1'b1;
      end else begin
        x_n = 10'(bx + L_SPEED);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) st_q <= S_SERVE;
    else     st_q <= st_n;
  end

  // Next-state logic.
  always_comb begin
    st_n = st_q;
    case (st_q)
      S_SERVE:  if (serve_req) st_n = S_PLAY;
      S_PLAY:   if (frame_tick && (miss_l || miss_r)) st_n = S_SCORED;
      S_SCORED: if (hold_done)
                  st_n = (p1_score >= L_WIN || p2_score >= L_WIN) ? S_OVER : S_SERVE;
      default:  st_n = S_OVER;
    endcase
  end

  // Next values of the registered outputs and game registers.
  always_comb begin
    ball_x_d    = ball_x;
    ball_y_d    = ball_y;
    dir_x_d     = dir_x;
    dir_y_d     = dir_y;
    serve_tog_d = serve_tog;
    server_d    = server;
    hold_cnt_d  = hold_cnt;
    p1_score_d  = p1_score;
    p2_score_d  = p2_score;
    point_d     = 1'b0;
    case (st_q)
      S_SERVE: begin
        ball_x_d = L_SX;
        ball_y_d = L_SY;
        if (serve_req) begin
          dir_x_d     = ~server;  // serve away from the server
          dir_y_d     = serve_tog;
          serve_tog_d = ~serve_tog;
        end
      end
      S_PLAY: begin
        if (frame_tick) begin
          if (miss_l || miss_r) begin
            // Ball stays where it was; the player who missed serves next.
            point_d    = 1'b1;
            hold_cnt_d = '0;
            if (miss_r) begin
              p1_score_d = (p1_score == 4'hF) ? p1_score : p1_score + 1'b1;
              server_d   = 1'b1;
            end else begin
              p2_score_d = (p2_score == 4'hF) ? p2_score : p2_score + 1'b1;
              server_d   = 1'b0;
            end
          end else begin
            ball_x_d = x_n;
            ball_y_d = y_n;
            dir_x_d  = dx_n;
            dir_y_d  = dy_n;
          end
        end
      end
      S_SCORED: begin
        if (frame_tick) hold_cnt_d = hold_inc;
        if (hold_done) begin
          ball_x_d = L_SX;
          ball_y_d = L_SY;
        end
      end
      default: begin
        ball_x_d = L_SX;
        ball_y_d = L_SY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ball_x    <= L_SX;
      ball_y    <= L_SY;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      serve_tog <= 1'b1;  // first serve goes down
      server    <= 1'b0;
      hold_cnt  <= '0;
      p1_score  <= '0;
      p2_score  <= '0;
      point     <= 1'b0;
    end else begin
      ball_x    <= ball_x_d;
      ball_y    <= ball_y_d;
      dir_x     <= dir_x_d;
      dir_y     <= dir_y_d;
      serve_tog <= serve_tog_d;
      server    <= server_d;
      hold_cnt  <= hold_cnt_d;
      p1_score  <= p1_score_d;
      p2_score  <= p2_score_d;
      point     <= point_d;
    end
  end

  assign state = st_q;

endmodule

// File: doc/pong_ball.md
Name: pong_ball

Overview:
- Game-logic stage that runs one ball-physics update per video frame.
- Owns serve/play/score sequencing and the two score counters.
- Drives the ball sprite position (top-left pixel) into the display stage. Consumes paddle positions and serve buttons from the paddle/input logic.
- The display stage is unchanged.

Parameters:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- BALL_SIZE, 8, ball width and height in pixels
- PADDLE_W, 8, paddle width in pixels
- PADDLE_H, 50, paddle height in pixels
- P1_X, 40, left paddle x (left edge)
- P2_X, 600, right paddle x (left edge)
- SPEED, 2, pixels moved per frame on each axis
- START_X, 320, ball x after reset or after a point
- START_Y, 240, ball y after reset or after a point
- HOLD_FRAMES, 60, frames the ball stays frozen after a miss
- WIN_SCORE, 9, score that ends the game

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- frame_tick  in  1  one-cycle pulse once per frame (start of vertical blank)
- p1_y  in  10  left paddle top edge
- p2_y  in  10  right paddle top edge
- p1_srv  in  1  player 1 serve button (level)
- p2_srv  in  1  player 2 serve button (level)
- ball_x  out  10  ball left edge
- ball_y  out  10  ball top edge
- p1_score  out  4  player 1 points
- p2_score  out  4  player 2 points
- state  out  2  0=SERVE, 1=PLAY, 2=SCORED, 3=GAMEOVER
- point  out  1  one-cycle pulse when a point is awarded

Behaviour:
- Reset and clocking:
  - One clock; rst is synchronous and active-high, sampled on posedge clk, and overrides all other inputs.
  - Reset values: ball (START_X, START_Y); scores 0; state SERVE; server = P1; dir_y = down; hold counter 0; point 0.
  - All outputs are registered.
- SERVE:
  - Ball is held at (START_X, START_Y).
  - In any cycle where the current server's srv input is 1, go to PLAY in the next cycle.
  - dir_x points away from the server: P1 serves right, P2 serves left.
  - dir_y takes the serve-toggle value; the toggle flips on every serve.
  - The non-server's srv is ignored. frame_tick is not required to serve.
- PLAY: position updates only on cycles with frame_tick=1. Both axes are evaluated in the same tick from pre-update values. All compares use 11-bit unsigned arithmetic with no wrap.
- Vertical axis:
  - Moving up with ball_y <= SPEED: ball_y <- 0, dir_y <- down.
  - Moving down with ball_y + BALL_SIZE + SPEED >= SCREEN_H: ball_y <- SCREEN_H - BALL_SIZE, dir_y <- up.
  - Otherwise ball_y moves by SPEED.
- Overlap with a paddle means ball_y + BALL_SIZE > py AND ball_y < py + PADDLE_H, using the pre-update ball_y.
- Horizontal axis, moving left (checked in order):
  - Bounce: ball_x >= P1_X + PADDLE_W, ball_x - SPEED < P1_X + PADDLE_W, and overlap with p1_y. Then ball_x <- P1_X + PADDLE_W, dir_x <- right.
  - Miss: else if ball_x <= SPEED. P2 scores.
  - Otherwise ball_x <- ball_x - SPEED.
- Horizontal axis, moving right:
  - Bounce: ball_x + BALL_SIZE <= P2_X, ball_x + BALL_SIZE + SPEED > P2_X, and overlap with p2_y. Then ball_x <- P2_X - BALL_SIZE, dir_x <- left.
  - Miss: else if ball_x + BALL_SIZE + SPEED >= SCREEN_W. P1 scores.
  - Otherwise ball_x <- ball_x + SPEED.
  - A ball that does not satisfy the bounce test passes through the paddle.
- Miss handling:
  - Ball position is not updated on the miss tick.
  - The scorer's score increments (saturates at 15). point pulses for exactly one cycle.
  - Server <- the player who missed. Hold counter <- 0. State goes to SCORED.
- SCORED:
  - Ball is frozen; the counter increments on each frame_tick.
  - On the frame_tick where the counter reaches HOLD_FRAMES, evaluate the scores:
    - If either score >= WIN_SCORE, go to GAMEOVER.
    - Otherwise go to SERVE.
  - In both cases the ball goes to (START_X, START_Y).
- GAMEOVER: ball held at start; scores held; exits only via rst. srv inputs are ignored.
- Paddle positions are used as given: out-of-range or wrapped p*_y values simply never overlap.

Test Plan:
1. Serve gating: reset, hold p2_srv=1 for 10 cycles -> state stays 0, ball (320,240). Pulse p1_srv -> state=1 next cycle; first frame_tick -> ball (322,242).
2. Bottom wall: P1 serve, p2_y=0, p1_y=0, pulse frame_tick.
   - Tick 115 -> ball_y=470.
   - Tick 116 -> ball_y=472, moving up.
   - Tick 117 -> ball_y=470.
3. Paddle bounce: continue case 2 with p2_y=400 from tick 130.
   - Tick 136 -> ball_x=592, ball_y=432.
   - Tick 137 -> ball_x=592, dir left.
   - Tick 138 -> ball_x=590.
4. Miss and score: same as case 3 but p2_y=240.
   - Tick 155 -> ball_x=630.
   - Tick 156 -> point pulse for 1 cycle, p1_score=1, state=2, ball frozen at x=630.
   - After 60 more ticks -> state=0, ball (320,240). Only p2_srv serves, ball then moves left.
5. Game over: force nine P1 points -> p1_score=9. After the hold -> state=3; srv inputs ignored. rst for 1 cycle -> scores 0, state 0.
6. Reset mid-play: assert rst during PLAY and a simultaneous frame_tick -> next cycle ball (320,240), state 0, point=0.
